// File: rtl/wdog_timer_pkg.sv
// Shared constants and state encoding for the host-communication watchdog.
package wdog_timer_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        EXPIRED  = 2'd2
    } wdog_state_t;

    localparam int          TICK_CYCLES_DEF = 2458;
    localparam logic [15:0] ADDR_PERIOD_DEF = 16'h000C;
    localparam logic [15:0] ADDR_STATUS_DEF = 16'h000D;

    // Bit positions inside the status read word
    localparam int STAT_ENABLED_BIT = 0;
    localparam int STAT_TIMEOUT_BIT = 1;
    localparam int STAT_ACTIVE_BIT  = 2;
    localparam int STAT_EXPCNT_LSB  = 8;
    localparam int STAT_COUNT_LSB   = 16;

endpackage

// File: rtl/wdog_timer_tick.sv
// Watchdog tick prescaler: one-cycle tick every TICK_CYCLES cycles while run is high.
module wdog_tick_gen #(
    parameter int TICK_CYCLES = 2458
) (
    input  logic sysclk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] prescaler;

    // Held at zero outside ARMED and restarted by every refresh
    always_ff @(posedge sysclk) begin
        if (reset || clr || !run) begin
            prescaler <= '0;
        end else if (prescaler == LAST) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick = run && !clr && (prescaler == LAST);

endmodule

// File: rtl/wdog_timer.sv
// Host watchdog: disables all amplifiers when the host stops writing registers.
// Optional WDOG_EXPIRE_COUNT_EN adds a saturating expiry counter to the status word.
module wdog_timer
    import wdog_timer_pkg::*;
#(
    parameter int          TICK_CYCLES = TICK_CYCLES_DEF,
    parameter logic [15:0] ADDR_PERIOD = ADDR_PERIOD_DEF,
    parameter logic [15:0] ADDR_STATUS = ADDR_STATUS_DEF
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        reg_wen,
    input  logic        blk_wen,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    output logic [4:1]  amp_disable,
    output logic        wdog_timeout,
    output logic        wdog_active
);

    wdog_state_t state;
    logic [15:0] period;
    logic [15:0] count;
    logic [7:0]  expire_cnt;
    logic        tick;
    logic        refresh;
    logic        period_wr;
    logic        clear_wr;
    logic        expire_evt;

    assign refresh   = reg_wen || blk_wen;
    assign period_wr = reg_wen && (reg_waddr == ADDR_PERIOD);
    assign clear_wr  = reg_wen && (reg_waddr == ADDR_STATUS) && reg_wdata[0];
    assign expire_evt = (state == ARMED) && !refresh && tick && (count == 16'd1);

    wdog_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .run    (state == ARMED),
        .clr    (refresh),
        .tick   (tick)
    );

    // Outputs follow the state one cycle later, so the disable asserts on the cycle after the expiring tick
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state        <= DISABLED;
            period       <= '0;
            count        <= '0;
            wdog_timeout <= 1'b0;
            wdog_active  <= 1'b0;
            amp_disable  <= 4'b0000;
        end else begin
            if (period_wr) begin
                period <= reg_wdata[15:0];
            end
            case (state)
                DISABLED: begin
                    if (period_wr && (reg_wdata[15:0] != 16'd0)) begin
                        state <= ARMED;
                        count <= reg_wdata[15:0];
                    end
                end
                ARMED: begin
                    if (period_wr) begin
                        if (reg_wdata[15:0] == 16'd0) begin
                            state <= DISABLED;
                        end else begin
                            count <= reg_wdata[15:0];
                        end
                    end else if (refresh) begin
                        count <= period;
                    end else if (tick) begin
                        if (count == 16'd1) begin
                            state <= EXPIRED;
                            count <= '0;
                        end else if (count != 16'd0) begin
                            count <= count - 16'd1;
                        end
                    end
                end
                EXPIRED: begin
                    if (clear_wr) begin
                        if (period != 16'd0) begin
                            state <= ARMED;
                            count <= period;
                        end else begin
                            state <= DISABLED;
                        end
                    end
                end
                default: state <= DISABLED;
            endcase
            wdog_timeout <= (state == EXPIRED);
            wdog_active  <= (state == ARMED);
            amp_disable  <= {4{state == EXPIRED}};
        end
    end

`ifdef WDOG_EXPIRE_COUNT_EN
    always_ff @(posedge sysclk) begin
        if (reset) begin
            expire_cnt <= '0;
        end else if (clear_wr && reg_wdata[1]) begin
            expire_cnt <= '0;
        end else if (expire_evt && (expire_cnt != 8'hFF)) begin
            expire_cnt <= expire_cnt + 8'd1;
        end
    end
`else
    assign expire_cnt = 8'h00;
`endif

    always_comb begin
        reg_rdata = 32'h0;
        if (reg_raddr == ADDR_PERIOD) begin
            reg_rdata = {16'h0, period};
        end else if (reg_raddr == ADDR_STATUS) begin
            reg_rdata[STAT_COUNT_LSB +: 16] = count;
            reg_rdata[STAT_EXPCNT_LSB +: 8] = expire_cnt;
            reg_rdata[STAT_ACTIVE_BIT]      = wdog_active;
            reg_rdata[STAT_TIMEOUT_BIT]     = wdog_timeout;
            reg_rdata[STAT_ENABLED_BIT]     = (state != DISABLED);
        end
    end

endmodule

// File: tb/tb_wdog_timer.sv
// Directed bench for wdog_timer with a short tick period; covers the table of register writes plus expiry corner cases.
module tb_wdog_timer;

    localparam int T = 4;

`ifdef WDOG_EXPIRE_COUNT_EN
    localparam logic [7:0] EXP_ONE = 8'h01;
    localparam logic [7:0] EXP_SAT = 8'hFF;
`else
    localparam logic [7:0] EXP_ONE = 8'h00;
    localparam logic [7:0] EXP_SAT = 8'h00;
`endif

    logic        sysclk = 1'b0;
    logic        reset;
    logic        reg_wen;
    logic        blk_wen;
    logic [15:0] reg_waddr;
    logic [31:0] reg_wdata;
    logic [15:0] reg_raddr;
    logic [31:0] reg_rdata;
    logic [4:1]  amp_disable;
    logic        wdog_timeout;
    logic        wdog_active;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        wen;
        logic        blk;
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [15:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_timeout;
        logic        exp_active;
    } vec_t;

    vec_t vecs[10];

    wdog_timer #(.TICK_CYCLES(T)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .reg_wen      (reg_wen),
        .blk_wen      (blk_wen),
        .reg_waddr    (reg_waddr),
        .reg_wdata    (reg_wdata),
        .reg_raddr    (reg_raddr),
        .reg_rdata    (reg_rdata),
        .amp_disable  (amp_disable),
        .wdog_timeout (wdog_timeout),
        .wdog_active  (wdog_active)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [31:0] status(input logic [15:0] cnt, input logic [7:0] ecnt,
                                           input logic act, input logic to, input logic en);
        return {cnt, ecnt, 5'b0, act, to, en};
    endfunction

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic applyStimulus(input logic wen, input logic blk, input logic [15:0] addr,
                                 input logic [31:0] data);
        reg_wen   = wen;
        blk_wen   = blk;
        reg_waddr = addr;
        reg_wdata = data;
        step();
        reg_wen = 1'b0;
        blk_wen = 1'b0;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic waitTimeout(input int budget, output int n);
        n = 0;
        while (!wdog_timeout && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic readStatus();
        reg_raddr = 16'h000D;
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int  n;
        logic saw;

        vecs[0] = '{1'b1, 1'b0, 16'h000D, 32'h1,       16'h000D, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h000C, 32'h0001_0005, 16'h000C, 32'h0000_0005, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h0055, 32'h0,       16'h000D, 32'h0005_0005, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h000C, 32'h7,       16'h000D, 32'h0007_0005, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0020, 32'h0,       16'h000C, 32'h0000_0007, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h000C, 32'h0,       16'h000D, 32'h0007_0004, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 16'h000C, 32'h9,       16'h000D, 32'h0007_0000, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h000C, 32'h2,       16'h000C, 32'h0000_0002, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 16'h0099, 32'h0,       16'h0099, 32'h0000_0000, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b0, 16'h000D, 32'h0,       16'h000D, 32'h0002_0005, 1'b0, 1'b1};

        reset = 1'b1; reg_wen = 1'b0; blk_wen = 1'b0;
        reg_waddr = '0; reg_wdata = '0; reg_raddr = 16'h000D;
        step();
        step();
        reset = 1'b0;
        #1;
        checkOutput("reset_status", reg_rdata, 32'h0);
        checkOutput("reset_timeout", {31'b0, wdog_timeout}, 32'h0);
        checkOutput("reset_active", {31'b0, wdog_active}, 32'h0);
        checkOutput("reset_amp", {28'b0, amp_disable}, 32'h0);
        reg_raddr = 16'h000C; #1;
        checkOutput("reset_period", reg_rdata, 32'h0);

        for (int i = 0; i < 10; i++) begin
            reg_raddr = vecs[i].raddr;
            applyStimulus(vecs[i].wen, vecs[i].blk, vecs[i].waddr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_rdata", i), reg_rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_timeout", i), {31'b0, wdog_timeout}, {31'b0, vecs[i].exp_timeout});
            checkOutput($sformatf("vec%0d_active", i), {31'b0, wdog_active}, {31'b0, vecs[i].exp_active});
            checkOutput($sformatf("vec%0d_amp", i), {28'b0, amp_disable}, {28'b0, {4{vecs[i].exp_timeout}}});
        end

        // Expiry latency from the period write
        doReset();
        readStatus();
        applyStimulus(1'b1, 1'b0, 16'h000C, 32'd3);
        waitTimeout(50, n);
        checkOutput("expiry_latency", n, 3 * T + 1);
        checkOutput("expiry_amp", {28'b0, amp_disable}, 32'hF);
        checkOutput("expiry_active", {31'b0, wdog_active}, 32'h0);

        // Writes while expired must not leave EXPIRED
        applyStimulus(1'b1, 1'b0, 16'h0040, 32'h1);
        applyStimulus(1'b0, 1'b1, 16'h000D, 32'h1);
        step();
        checkOutput("expired_hold_timeout", {31'b0, wdog_timeout}, 32'h1);
        checkOutput("expired_hold_status", reg_rdata, status(16'd0, EXP_ONE, 1'b0, 1'b1, 1'b1));
        applyStimulus(1'b1, 1'b0, 16'h000D, 32'h1);
        checkOutput("clear_status", reg_rdata, status(16'd3, EXP_ONE, 1'b0, 1'b1, 1'b1));
        step();
        checkOutput("clear_amp", {28'b0, amp_disable}, 32'h0);
        checkOutput("clear_timeout", {31'b0, wdog_timeout}, 32'h0);
        checkOutput("clear_active", {31'b0, wdog_active}, 32'h1);

        // Keep-alive refresh every 2*T cycles
        applyStimulus(1'b0, 1'b1, 16'h0077, 32'h0);
        for (int k = 0; k < 4; k++) begin
            saw = 1'b0;
            repeat (2 * T - 1) begin
                step();
                if (wdog_timeout) saw = 1'b1;
            end
            applyStimulus(1'b1, 1'b0, 16'h0123, 32'h0);
            checkOutput($sformatf("keepalive%0d_timeout", k), {31'b0, saw | wdog_timeout}, 32'h0);
            checkOutput($sformatf("keepalive%0d_count", k), {16'b0, reg_rdata[31:16]}, 32'd3);
        end

        // Refresh landing on the final tick
        repeat (3 * T - 1) step();
        checkOutput("final_tick_count", {16'b0, reg_rdata[31:16]}, 32'd1);
        applyStimulus(1'b0, 1'b1, 16'h0005, 32'h0);
        checkOutput("final_tick_reload", reg_rdata, status(16'd3, EXP_ONE, 1'b1, 1'b0, 1'b1));
        step();
        step();
        checkOutput("final_tick_no_expiry", {31'b0, wdog_timeout}, 32'h0);

        // Period 0 while armed freezes the count and disables
        applyStimulus(1'b0, 1'b1, 16'h0005, 32'h0);
        repeat (T) step();
        applyStimulus(1'b1, 1'b0, 16'h000C, 32'h0);
        checkOutput("disable_status", reg_rdata, status(16'd2, EXP_ONE, 1'b1, 1'b0, 1'b0));
        saw = 1'b0;
        repeat (100 * T) begin
            step();
            if (wdog_timeout) saw = 1'b1;
        end
        checkOutput("disable_no_expiry", {31'b0, saw}, 32'h0);
        checkOutput("disable_frozen", reg_rdata, status(16'd2, EXP_ONE, 1'b0, 1'b0, 1'b0));
        applyStimulus(1'b1, 1'b0, 16'h000D, 32'h1);
        step();
        checkOutput("disable_clear_stays", reg_rdata, status(16'd2, EXP_ONE, 1'b0, 1'b0, 1'b0));

        // Reset while expired and mid-countdown
        applyStimulus(1'b1, 1'b0, 16'h000C, 32'h1);
        waitTimeout(20, n);
        checkOutput("period1_latency", n, T + 1);
        doReset();
        checkOutput("reset_expired_status", reg_rdata, 32'h0);
        checkOutput("reset_expired_amp", {28'b0, amp_disable}, 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h000C, 32'd3);
        repeat (T + 1) step();
        doReset();
        checkOutput("reset_mid_status", reg_rdata, 32'h0);
        checkOutput("reset_mid_active", {31'b0, wdog_active}, 32'h0);
        reg_raddr = 16'h000C; #1;
        checkOutput("reset_mid_period", reg_rdata, 32'h0);

        // Many expiries to exercise the optional saturating counter
        readStatus();
        applyStimulus(1'b1, 1'b0, 16'h000C, 32'h1);
        for (int i = 0; i < 300; i++) begin
            waitTimeout(20, n);
            if (!wdog_timeout) begin
                checkOutput("expire_loop_wait", {31'b0, wdog_timeout}, 32'h1);
                break;
            end
            if (i < 299) begin
                applyStimulus(1'b1, 1'b0, 16'h000D, 32'h1);
                step();
            end
        end
        checkOutput("expire_cnt_sat", {24'b0, reg_rdata[15:8]}, {24'b0, EXP_SAT});
        applyStimulus(1'b1, 1'b0, 16'h000D, 32'h3);
        checkOutput("expire_cnt_clear", {24'b0, reg_rdata[15:8]}, 32'h0);
        checkOutput("expire_clear_count", {16'b0, reg_rdata[31:16]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
